// File: rtl/ibex_pkg.sv
// Shared types and helpers for the register-file write-side arbiter.
package ibex_pkg;

  typedef struct packed {
    logic        valid;
    logic [4:0]  addr;
    logic [31:0] data;
  } rf_wr_req_t;

  // RV32E has 16 registers: address bit 4 is ignored, exactly as the RF does.
  function automatic logic [4:0] rf_addr_mask(input logic [4:0] addr, input logic rv32e);
    return rv32e ? {1'b0, addr[3:0]} : addr;
  endfunction

endpackage

// File: rtl/ibex_rf_wb_fifo.sv
// In-order buffer for EX writes that lost the RF port. Entries can be killed by
// address in place and are exposed oldest-first for the forwarding lookup.
module ibex_rf_wb_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 2,
  localparam int unsigned PtrW     = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW     = $clog2(Depth + 1)
) (
  input  logic                            clk_int,
  input  logic                            rst_ni,
  input  logic                            push_i,
  input  logic [4:0]                      push_addr_i,
  input  logic [DataWidth-1:0]            push_data_i,
  input  logic                            pop_i,
  input  logic                            kill_i,
  input  logic [4:0]                      kill_addr_i,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [CntW-1:0]                 cnt_o,
  output logic                            head_alive_o,
  output logic [4:0]                      head_addr_o,
  output logic [DataWidth-1:0]            head_data_o,
  output logic [Depth-1:0]                age_vld_o,
  output logic [Depth-1:0][4:0]           age_addr_o,
  output logic [Depth-1:0][DataWidth-1:0] age_data_o
);

  logic [PtrW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic [Depth-1:0]               alive_q, alive_d;
  logic [Depth-1:0][4:0]          addr_q, addr_d;
  logic [Depth-1:0][DataWidth-1:0] data_q, data_d;
  logic [PtrW:0]                  age_idx;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o       = (cnt_q == CntW'(Depth));
  assign empty_o      = (cnt_q == '0);
  assign cnt_o        = cnt_q;
  assign head_alive_o = alive_q[rd_ptr_q];
  assign head_addr_o  = addr_q[rd_ptr_q];
  assign head_data_o  = data_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    alive_d  = alive_q;
    addr_d   = addr_q;
    data_d   = data_q;

    // Kill before push so an entry written this cycle stays alive.
    if (kill_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        if (addr_q[i] == kill_addr_i) begin
          alive_d[i] = 1'b0;
        end
      end
    end

    if (pop_i) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    if (push_i) begin
      alive_d[wr_ptr_q] = 1'b1;
      addr_d[wr_ptr_q]  = push_addr_i;
      data_d[wr_ptr_q]  = push_data_i;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end

    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    age_vld_o  = '0;
    age_addr_o = '0;
    age_data_o = '0;
    age_idx    = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      age_idx = {1'b0, rd_ptr_q} + (PtrW + 1)'(i);
      if (age_idx >= (PtrW + 1)'(Depth)) begin
        age_idx = age_idx - (PtrW + 1)'(Depth);
      end
      age_vld_o[i]  = (CntW'(i) < cnt_q) & alive_q[age_idx[PtrW-1:0]];
      age_addr_o[i] = addr_q[age_idx[PtrW-1:0]];
      age_data_o[i] = data_q[age_idx[PtrW-1:0]];
    end
  end

  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      alive_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      alive_q  <= alive_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Merges EX and LSU writebacks onto the single RF write port. LSU always wins;
// displaced EX writes wait in a small FIFO and are visible to ID via forwarding.
module ibex_rf_wb_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned FifoDepth = 2,
  localparam int unsigned CntW     = $clog2(FifoDepth + 1)
) (
  input  logic                 clk_int,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [4:0]           fwd_raddr_a_i,
  input  logic [4:0]           fwd_raddr_b_i,
  output logic                 fwd_hit_a_o,
  output logic                 fwd_hit_b_o,
  output logic [DataWidth-1:0] fwd_data_a_o,
  output logic [DataWidth-1:0] fwd_data_b_o,
  output logic [CntW-1:0]      fifo_cnt_o
);

  logic [4:0]           ex_addr, lsu_addr;
  logic                 ex_live, lsu_live;
  logic                 fifo_push, fifo_pop;
  logic                 fifo_full, fifo_empty;
  logic                 head_alive;
  logic [4:0]           head_addr;
  logic [DataWidth-1:0] head_data;

  logic [FifoDepth-1:0]                age_vld;
  logic [FifoDepth-1:0][4:0]           age_addr;
  logic [FifoDepth-1:0][DataWidth-1:0] age_data;

  logic                 rf_we_q, rf_we_d;
  logic [4:0]           rf_waddr_q, rf_waddr_d;
  logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;

  logic [1:0][4:0]           fwd_raddr;
  logic [1:0]                fwd_hit;
  logic [1:0][DataWidth-1:0] fwd_data;

  assign ex_addr  = rf_addr_mask(ex_waddr_i, RV32E);
  assign lsu_addr = rf_addr_mask(lsu_waddr_i, RV32E);

  // x0 writes are accepted like any other but go nowhere.
  assign ex_ready_o = ~fifo_full;
  assign ex_live    = ex_valid_i & ex_ready_o & (ex_addr != 5'd0);
  assign lsu_live   = lsu_valid_i & (lsu_addr != 5'd0);

  ibex_rf_wb_fifo #(
    .DataWidth (DataWidth),
    .Depth     (FifoDepth)
  ) u_fifo (
    .clk_int      (clk_int),
    .rst_ni       (rst_ni),
    .push_i       (fifo_push),
    .push_addr_i  (ex_addr),
    .push_data_i  (ex_wdata_i),
    .pop_i        (fifo_pop),
    .kill_i       (lsu_live),
    .kill_addr_i  (lsu_addr),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .cnt_o        (fifo_cnt_o),
    .head_alive_o (head_alive),
    .head_addr_o  (head_addr),
    .head_data_o  (head_data),
    .age_vld_o    (age_vld),
    .age_addr_o   (age_addr),
    .age_data_o   (age_data)
  );

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    fifo_pop   = 1'b0;
    fifo_push  = 1'b0;
    if (lsu_live) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = lsu_addr;
      rf_wdata_d = lsu_wdata_i;
      fifo_push  = ex_live;
    end else if (!fifo_empty) begin
      // A killed head still drains, issuing an idle write slot.
      fifo_pop   = 1'b1;
      rf_we_d    = head_alive;
      rf_waddr_d = head_addr;
      rf_wdata_d = head_data;
      fifo_push  = ex_live;
    end else if (ex_live) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = ex_addr;
      rf_wdata_d = ex_wdata_i;
    end
  end

  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;

  assign fwd_raddr[0] = rf_addr_mask(fwd_raddr_a_i, RV32E);
  assign fwd_raddr[1] = rf_addr_mask(fwd_raddr_b_i, RV32E);

  // Output stage is oldest; FIFO entries scanned head to tail so the youngest wins.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    for (int p = 0; p < 2; p++) begin
      if (fwd_raddr[p] != 5'd0) begin
        if (rf_we_q && (rf_waddr_q == fwd_raddr[p])) begin
          fwd_hit[p]  = 1'b1;
          fwd_data[p] = rf_wdata_q;
        end
        for (int i = 0; i < int'(FifoDepth); i++) begin
          if (age_vld[i] && (age_addr[i] == fwd_raddr[p])) begin
            fwd_hit[p]  = 1'b1;
            fwd_data[p] = age_data[i];
          end
        end
      end
    end
  end

  assign fwd_hit_a_o  = fwd_hit[0];
  assign fwd_hit_b_o  = fwd_hit[1];
  assign fwd_data_a_o = fwd_data[0];
  assign fwd_data_b_o = fwd_data[1];

endmodule
